lpbk_swap_engine: RTL



---
 rtl/lpbk_pkg.sv | 39 +++
 rtl/lpbk_word_fmt.sv | 40 ++++
 rtl/lpbk_swap_engine.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lpbk_pkg.sv
// Shared encodings, header layout and word-count helper for the loopback swap engine.
package lpbk_pkg;

   typedef enum logic [7:0] {
      ST_IDLE  = 8'b0000_0001,
      ST_POP   = 8'b0000_0010,
      ST_LEN   = 8'b0000_0100,
      ST_WAIT  = 8'b0000_1000,
      ST_XFER  = 8'b0001_0000,
      ST_FLUSH = 8'b0010_0000,
      ST_DROP  = 8'b0100_0000,
      ST_DONE  = 8'b1000_0000
   } state_t;

   localparam logic [1:0]  MODE_PASS     = 2'd0;
   localparam logic [1:0]  MODE_MAC      = 2'd1;
   localparam logic [1:0]  MODE_MACIP    = 2'd2;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

   localparam int WORD_BYTES  = 32;
   localparam int HDR_BYTES   = 8;
   localparam int MAC_DA_OFS  = 8;
   localparam int MAC_SA_OFS  = 14;
   localparam int MAC_LEN     = 6;
   localparam int ETYPE_OFS   = 12;
   localparam int IP_SRC_OFS  = 2;
   localparam int IP_DST_OFS  = 6;
   localparam int IP_ADDR_LEN = 4;
   localparam int MIN_MAC_LEN = 12;
   localparam int MIN_IP_LEN  = 34;

   function automatic logic [11:0] words_for(input logic [16:0] nbytes);
      logic [16:0] s;
      s = nbytes + 17'd31;
      return s[16:5];
   endfunction

endpackage

// File: rtl/lpbk_word_fmt.sv
// Builds one TX word: header insert / 8-byte shift, MAC and IPv4 address swap, tail zeroing.
module lpbk_word_fmt
   import lpbk_pkg::*;
(
   input  logic [255:0] cur,
   input  logic [255:0] prev,
   input  logic [11:0]  idx,
   input  logic [15:0]  len,
   input  logic         mac_swap,
   input  logic         ip_swap,
   output logic [255:0] word
);

   logic [255:0] shifted;
   logic [255:0] swapped;
   logic [16:0]  last_ofs;
   logic         unused_bits;

   assign unused_bits = ^{cur[255:192], prev[191:0]};

   always_comb begin
      shifted = (idx == 12'd0) ? {cur[191:0], 48'h0, len} : {cur[191:0], prev[255:192]};
      swapped = shifted;
      if (mac_swap && idx == 12'd0) begin
         swapped[MAC_DA_OFS*8 +: MAC_LEN*8] = shifted[MAC_SA_OFS*8 +: MAC_LEN*8];
         swapped[MAC_SA_OFS*8 +: MAC_LEN*8] = shifted[MAC_DA_OFS*8 +: MAC_LEN*8];
      end
      if (ip_swap && idx == 12'd1) begin
         swapped[IP_SRC_OFS*8 +: IP_ADDR_LEN*8] = shifted[IP_DST_OFS*8 +: IP_ADDR_LEN*8];
         swapped[IP_DST_OFS*8 +: IP_ADDR_LEN*8] = shifted[IP_SRC_OFS*8 +: IP_ADDR_LEN*8];
      end
      // TX byte offset of byte b in this word is idx*32+b; keep up to the last frame byte
      last_ofs = {1'b0, len} + 17'(HDR_BYTES - 1);
      word = swapped;
      for (int b = 0; b < WORD_BYTES; b++) begin
         if ({idx, 5'(b)} > last_ofs) word[b*8 +: 8] = 8'h0;
      end
   end

endmodule

// File: rtl/lpbk_swap_engine.sv
// Loopback engine: pops a descriptor per frame, admits it against TX space, and streams
// RX words to TX with a length header, optional address swap and tail zeroing.
//
//   state | meaning
//   IDLE  | wait for a descriptor, pop it
//   POP   | descriptor read in flight
//   LEN   | latch length and mode, compute RX/TX word counts
//   WAIT  | wait for TX space for the whole frame
//   XFER  | read RX words, write formatted TX words
//   FLUSH | write the trailing word holding the last 8 frame bytes
//   DROP  | read and discard an oversize frame
//   DONE  | update statistics
module lpbk_swap_engine
   import lpbk_pkg::*;
#(
   parameter int TX_USEDW_W = 13,
   parameter int TX_DEPTH   = 4096,
   parameter int MAX_LEN    = 9600
)(
   input  logic                  clk,
   input  logic                  reset_,
   input  logic [1:0]            cfg_mode,
   input  logic [255:0]          rx_mac_data,
   input  logic                  rx_mac_empty,
   output logic                  rx_mac_rd,
   output logic                  cs_fifo_rd_en,
   input  logic                  cs_fifo_empty,
   input  logic [63:0]           ipcs_fifo_dout,
   output logic                  tx_mac_wr,
   output logic [255:0]          tx_mac_data,
   input  logic                  tx_mac_full,
   input  logic [TX_USEDW_W-1:0] tx_mac_usedw,
   output logic [31:0]           stat_frm_cnt,
   output logic [31:0]           stat_byte_cnt,
   output logic [15:0]           stat_drop_cnt
);

   state_t       state, state_nx;
   logic [15:0]  len_in, len_q;
   logic [1:0]   mode_q;
   logic [11:0]  rx_words, tx_words, rd_cnt, wr_cnt;
   logic         looped;
   logic         rd_q, pend_vld, out_vld;
   logic [255:0] pend_raw, prev_raw, fmt_cur, fmt_word;
   logic         out_free, load_rx, load_flush, pend_set;
   logic         mac_swap, ip_swap, adm_ok;
   logic [TX_USEDW_W:0] adm_sum;
   logic         unused_desc;

   assign len_in      = ipcs_fifo_dout[63:48];
   assign unused_desc = ^ipcs_fifo_dout[47:0];

   assign adm_sum = {1'b0, tx_mac_usedw} + (TX_USEDW_W+1)'(tx_words);
   assign adm_ok  = adm_sum <= (TX_USEDW_W+1)'(TX_DEPTH - 1);

   // One-deep output register plus one pending slot absorb the read in flight when TX stalls
   assign out_free   = !out_vld || !tx_mac_full;
   assign load_rx    = (state == ST_XFER) && (rd_q || pend_vld) && out_free;
   assign pend_set   = (state == ST_XFER) && rd_q && !out_free;
   assign load_flush = (state == ST_FLUSH) && out_free;
   assign fmt_cur    = load_flush ? 256'h0 : (pend_vld ? pend_raw : rx_mac_data);

   assign mac_swap = (mode_q != MODE_PASS) && (len_q >= 16'(MIN_MAC_LEN));
   assign ip_swap  = (mode_q >= MODE_MACIP) && (len_q >= 16'(MIN_IP_LEN)) &&
                     ({prev_raw[ETYPE_OFS*8 +: 8], prev_raw[(ETYPE_OFS+1)*8 +: 8]} == ETH_TYPE_IPV4);

   lpbk_word_fmt u_fmt (
      .cur      (fmt_cur),
      .prev     (prev_raw),
      .idx      (wr_cnt),
      .len      (len_q),
      .mac_swap (mac_swap),
      .ip_swap  (ip_swap),
      .word     (fmt_word)
   );

   always_ff @(posedge clk) begin
      if (!reset_) state <= ST_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (!cs_fifo_empty) state_nx = ST_POP;
         ST_POP:   state_nx = ST_LEN;
         ST_LEN: begin
            if (len_in == 16'd0)               state_nx = ST_DONE;
            else if (len_in > 16'(MAX_LEN))    state_nx = ST_DROP;
            else                               state_nx = ST_WAIT;
         end
         ST_WAIT:  if (adm_ok && !tx_mac_full) state_nx = ST_XFER;
         ST_XFER: begin
            if (load_rx && wr_cnt == rx_words - 12'd1)
               state_nx = (tx_words > rx_words) ? ST_FLUSH : ST_DONE;
         end
         ST_FLUSH: if (out_free) state_nx = ST_DONE;
         ST_DROP:  if (rx_mac_rd && rd_cnt == rx_words - 12'd1) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      cs_fifo_rd_en = reset_ && (state == ST_IDLE) && !cs_fifo_empty;
      rx_mac_rd     = reset_ && !rx_mac_empty && (rd_cnt < rx_words) &&
                      (((state == ST_XFER) && !tx_mac_full) || (state == ST_DROP));
      tx_mac_wr     = out_vld && !tx_mac_full;
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         len_q         <= '0;
         mode_q        <= '0;
         rx_words      <= '0;
         tx_words      <= '0;
         rd_cnt        <= '0;
         wr_cnt        <= '0;
         looped        <= 1'b0;
         rd_q          <= 1'b0;
         pend_vld      <= 1'b0;
         pend_raw      <= '0;
         prev_raw      <= '0;
         out_vld       <= 1'b0;
         tx_mac_data   <= '0;
         stat_frm_cnt  <= '0;
         stat_byte_cnt <= '0;
         stat_drop_cnt <= '0;
      end else begin
         rd_q <= rx_mac_rd;
         if (tx_mac_wr) out_vld <= 1'b0;
         if (state == ST_LEN) begin
            len_q    <= len_in;
            mode_q   <= cfg_mode;
            rx_words <= words_for({1'b0, len_in});
            tx_words <= words_for({1'b0, len_in} + 17'd8);
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            looped   <= (len_in != 16'd0) && (len_in <= 16'(MAX_LEN));
         end
         if (rx_mac_rd) rd_cnt <= rd_cnt + 12'd1;
         if (load_rx || load_flush) begin
            out_vld     <= 1'b1;
            tx_mac_data <= fmt_word;
            wr_cnt      <= wr_cnt + 12'd1;
         end
         if (load_rx) begin
            prev_raw <= fmt_cur;
            pend_vld <= 1'b0;
         end else if (pend_set) begin
            pend_vld <= 1'b1;
            pend_raw <= rx_mac_data;
         end
         if (state == ST_DONE) begin
            if (looped) begin
               stat_frm_cnt  <= stat_frm_cnt + 32'd1;
               stat_byte_cnt <= stat_byte_cnt + {16'h0, len_q};
            end else begin
               stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
         end
      end
   end

endmodule
